// File: rtl/spi_reg_burst.sv
// SPI slave register port: command byte, then REG_W-bit words with address auto-increment.
// CPOL/CPHA are latched per frame; a mid-word abort raises a sticky frame error.
`timescale 1ns/1ps
module spi_reg_burst #(
    parameter int ADDR_W      = 6,
    parameter int REG_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [1:0]        spi_mode,
    input  logic              mosi,
    input  logic              sclk,
    input  logic              nss,
    output logic              miso,
    output logic [ADDR_W-1:0] reg_addr,
    input  logic [REG_W-1:0]  reg_data_i,
    output logic              reg_rd_strb,
    output logic [REG_W-1:0]  reg_data_o,
    output logic              reg_data_o_vld,
    input  logic [7:0]        status,
    output logic [5:0]        fastcmd,
    output logic              fastcmd_vld,
    output logic              frame_err
);

    localparam int CNT_W = $clog2(REG_W);

    typedef enum logic [1:0] {WAIT_DESEL, IDLE, CMD, DATA} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] nss_sync;
    logic                   sclk_p0;
    logic                   sclk_p1;
    logic                   mosi_p0;
    logic                   nss_p0;
    logic                   nss_p1;

    state_t                 state;
    logic [1:0]             mode_r;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_nxt;
    logic [REG_W-2:0]       isr;
    logic [REG_W-1:0]       osr;
    logic [REG_W-1:0]       word_in;
    logic [7:0]             cmd_byte;
    logic                   skip;
    logic                   is_wr;
    logic                   rd_vld_p1;

    logic                   sclk_rise;
    logic                   sclk_fall;
    logic                   lead_edge;
    logic                   trail_edge;
    logic                   sample_edge;
    logic                   change_edge;
    logic                   nss_fall;
    logic                   active;
    logic                   word_done;

    // Input synchronisers; the extra flop on sclk/nss gives edge detection
    always_ff @(posedge clk) begin
        if (!nrst) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            nss_sync  <= '0;
            sclk_p1   <= 1'b0;
            nss_p1    <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            nss_sync  <= {nss_sync[SYNC_STAGES-2:0], nss};
            sclk_p1   <= sclk_p0;
            nss_p1    <= nss_p0;
        end
    end

    assign sclk_p0 = sclk_sync[SYNC_STAGES-1];
    assign mosi_p0 = mosi_sync[SYNC_STAGES-1];
    assign nss_p0  = nss_sync[SYNC_STAGES-1];
    assign miso    = osr[REG_W-1];

    always_comb begin
        sclk_rise   = sclk_p0 & ~sclk_p1;
        sclk_fall   = ~sclk_p0 & sclk_p1;
        nss_fall    = nss_p1 & ~nss_p0;
        lead_edge   = mode_r[1] ? sclk_fall : sclk_rise;
        trail_edge  = mode_r[1] ? sclk_rise : sclk_fall;
        sample_edge = mode_r[0] ? trail_edge : lead_edge;
        change_edge = mode_r[0] ? lead_edge : trail_edge;
        active      = (state == CMD) || (state == DATA);
        word_in     = {isr, mosi_p0};
        cmd_byte    = word_in[7:0];
        word_done   = active && sample_edge &&
                      (((state == CMD) && (cnt == CNT_W'(7))) ||
                       ((state == DATA) && (cnt == CNT_W'(REG_W - 1))));
        cnt_nxt     = cnt;
        if (active && sample_edge) begin
            cnt_nxt = word_done ? '0 : cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state          <= WAIT_DESEL;
            mode_r         <= '0;
            cnt            <= '0;
            isr            <= '0;
            osr            <= '0;
            skip           <= 1'b0;
            is_wr          <= 1'b0;
            rd_vld_p1      <= 1'b0;
            reg_addr       <= '0;
            reg_rd_strb    <= 1'b0;
            reg_data_o     <= '0;
            reg_data_o_vld <= 1'b0;
            fastcmd        <= '0;
            fastcmd_vld    <= 1'b0;
            frame_err      <= 1'b0;
        end else begin
            reg_data_o_vld <= 1'b0;
            fastcmd_vld    <= 1'b0;
            reg_rd_strb    <= rd_vld_p1;
            rd_vld_p1      <= 1'b0;
            if (reg_data_o_vld) begin
                reg_addr <= reg_addr + 1'b1;
            end
            case (state)
                WAIT_DESEL: begin
                    if (nss_p0) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (nss_fall) begin
                        mode_r    <= spi_mode;
                        cnt       <= '0;
                        osr       <= REG_W'(status) << (REG_W - 8);
                        skip      <= spi_mode[0];
                        frame_err <= 1'b0;
                        state     <= CMD;
                    end
                end
                CMD, DATA: begin
                    if (change_edge) begin
                        if (skip) begin
                            skip <= 1'b0;
                        end else begin
                            osr <= {osr[REG_W-2:0], 1'b0};
                        end
                    end
                    // A fresh read word holds its MSB through the next change edge
                    if (reg_rd_strb) begin
                        osr  <= reg_data_i;
                        skip <= 1'b1;
                    end
                    if (sample_edge) begin
                        isr <= word_in[REG_W-2:0];
                        cnt <= cnt_nxt;
                    end
                    if (word_done && (state == CMD)) begin
                        reg_addr <= cmd_byte[ADDR_W-1:0];
                        case (cmd_byte[7:6])
                            2'b11: begin
                                fastcmd     <= cmd_byte[5:0];
                                fastcmd_vld <= 1'b1;
                                osr         <= '0;
                                state       <= WAIT_DESEL;
                            end
                            2'b01: begin
                                osr   <= '0;
                                state <= WAIT_DESEL;
                            end
                            2'b00: begin
                                is_wr       <= 1'b0;
                                reg_rd_strb <= 1'b1;
                                state       <= DATA;
                            end
                            2'b10: begin
                                is_wr <= 1'b1;
                                osr   <= '0;
                                skip  <= 1'b1;
                                state <= DATA;
                            end
                        endcase
                    end
                    if (word_done && (state == DATA)) begin
                        if (is_wr) begin
                            reg_data_o     <= word_in;
                            reg_data_o_vld <= 1'b1;
                        end else begin
                            reg_addr  <= reg_addr + 1'b1;
                            rd_vld_p1 <= 1'b1;
                        end
                    end
                    // Deselect ends the frame; only a partial word counts as an abort
                    if (nss_p0) begin
                        if (cnt_nxt != '0) begin
                            frame_err <= 1'b1;
                        end
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_reg_burst.sv
// Scoreboard bench for spi_reg_burst: directed SPI frames in all four modes, strobes checked
// by a monitor against queued expectations, miso checked against hand-computed words.
`timescale 1ns/1ps
module tb_spi_reg_burst;

    localparam int ADDR_W      = 6;
    localparam int REG_W       = 16;
    localparam int SYNC_STAGES = 2;
    localparam int H           = 80;

    logic              clk;
    logic              nrst;
    logic [1:0]        spi_mode;
    logic              mosi;
    logic              sclk;
    logic              nss;
    logic              miso;
    logic [ADDR_W-1:0] reg_addr;
    logic [REG_W-1:0]  reg_data_i;
    logic              reg_rd_strb;
    logic [REG_W-1:0]  reg_data_o;
    logic              reg_data_o_vld;
    logic [7:0]        status;
    logic [5:0]        fastcmd;
    logic              fastcmd_vld;
    logic              frame_err;

    logic [15:0] mem [64];
    logic [63:0] rx;

    logic [31:0] wr_addr_q [$];
    logic [31:0] wr_data_q [$];
    logic [31:0] rd_addr_q [$];
    logic [31:0] fc_q [$];

    int checks = 0;
    int errors = 0;

    spi_reg_burst #(
        .ADDR_W(ADDR_W),
        .REG_W(REG_W),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk(clk),
        .nrst(nrst),
        .spi_mode(spi_mode),
        .mosi(mosi),
        .sclk(sclk),
        .nss(nss),
        .miso(miso),
        .reg_addr(reg_addr),
        .reg_data_i(reg_data_i),
        .reg_rd_strb(reg_rd_strb),
        .reg_data_o(reg_data_o),
        .reg_data_o_vld(reg_data_o_vld),
        .status(status),
        .fastcmd(fastcmd),
        .fastcmd_vld(fastcmd_vld),
        .frame_err(frame_err)
    );

    assign reg_data_i = mem[reg_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk($sformatf("%s_miso", tag), 32'(miso), 32'h0);
        chk($sformatf("%s_reg_addr", tag), 32'(reg_addr), 32'h0);
        chk($sformatf("%s_rd_strb", tag), 32'(reg_rd_strb), 32'h0);
        chk($sformatf("%s_data_o", tag), 32'(reg_data_o), 32'h0);
        chk($sformatf("%s_data_o_vld", tag), 32'(reg_data_o_vld), 32'h0);
        chk($sformatf("%s_fastcmd", tag), 32'(fastcmd), 32'h0);
        chk($sformatf("%s_fastcmd_vld", tag), 32'(fastcmd_vld), 32'h0);
        chk($sformatf("%s_frame_err", tag), 32'(frame_err), 32'h0);
    endtask

    // SPI master: tx bits are left-aligned (bit i is tx[63-i]); miso captured at each sample edge
    task automatic spi_xfer(input logic [1:0] mode, input logic [63:0] tx, input int n,
                            input bit end_frame, output logic [63:0] rxv);
        logic cpol;
        logic cpha;
        cpol     = mode[1];
        cpha     = mode[0];
        rxv      = '0;
        spi_mode = mode;
        sclk     = cpol;
        mosi     = 1'b0;
        #(H);
        nss = 1'b0;
        #(H);
        for (int i = 0; i < n; i++) begin
            if (!cpha) begin
                mosi = tx[63-i];
                #(H);
                rxv[63-i] = miso;
                sclk = ~cpol;
                #(H);
                sclk = cpol;
            end else begin
                sclk = ~cpol;
                mosi = tx[63-i];
                #(H);
                rxv[63-i] = miso;
                sclk = cpol;
                #(H);
            end
        end
        #(H);
        if (end_frame) begin
            nss = 1'b1;
            #(2*H);
        end
    endtask

    always @(negedge clk) begin
        if (nrst) begin
            if (reg_data_o_vld) begin
                if (wr_addr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_wr: got write strobe data 0x%0h, required none", reg_data_o);
                end else begin
                    chk("wr_addr", 32'(reg_addr), wr_addr_q.pop_front());
                    chk("wr_data", 32'(reg_data_o), wr_data_q.pop_front());
                end
            end
            if (reg_rd_strb) begin
                if (rd_addr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rd: got read strobe at addr 0x%0h, required none", reg_addr);
                end else begin
                    chk("rd_addr", 32'(reg_addr), rd_addr_q.pop_front());
                end
            end
            if (fastcmd_vld) begin
                if (fc_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_fastcmd: got fastcmd 0x%0h, required none", fastcmd);
                end else begin
                    chk("fastcmd", 32'(fastcmd), fc_q.pop_front());
                end
            end
        end
    end

    initial begin
        for (int a = 0; a < 64; a++) mem[a] = 16'h0000;
        mem[62] = 16'h1357;
        mem[63] = 16'h2468;
        mem[0]  = 16'hACE1;
        nrst     = 1'b0;
        nss      = 1'b1;
        sclk     = 1'b0;
        mosi     = 1'b0;
        spi_mode = 2'b00;
        status   = 8'hA5;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        nrst = 1'b1;
        repeat (4) @(negedge clk);

        // T1: mode 0 single write of 0xBEEF to address 5
        wr_addr_q.push_back(32'h05); wr_data_q.push_back(32'hBEEF);
        spi_xfer(2'b00, {8'h85, 16'hBEEF, 40'h0}, 24, 1'b1, rx);
        chk("t1_status", 32'(rx[63:56]), 32'hA5);
        chk("t1_addr_after", 32'(reg_addr), 32'h06);
        chk("t1_frame_err", 32'(frame_err), 32'h0);

        // T2: mode 3 read burst from 0x3E, wrapping to 0x00
        rd_addr_q.push_back(32'h3E); rd_addr_q.push_back(32'h3F);
        rd_addr_q.push_back(32'h00); rd_addr_q.push_back(32'h01);
        spi_xfer(2'b11, {8'h3E, 56'h0}, 56, 1'b1, rx);
        chk("t2_status", 32'(rx[63:56]), 32'hA5);
        chk("t2_word0", 32'(rx[55:40]), 32'h1357);
        chk("t2_word1", 32'(rx[39:24]), 32'h2468);
        chk("t2_word2", 32'(rx[23:8]), 32'hACE1);

        // T3: fast command in modes 1 and 2, trailing clocks ignored
        fc_q.push_back(32'h09);
        spi_xfer(2'b01, {8'hC9, 8'h85, 48'h0}, 16, 1'b1, rx);
        chk("t3_m1_status", 32'(rx[63:56]), 32'hA5);
        fc_q.push_back(32'h09);
        spi_xfer(2'b10, {8'hC9, 8'h85, 48'h0}, 16, 1'b1, rx);
        chk("t3_m2_status", 32'(rx[63:56]), 32'hA5);

        // T4: write aborted after 5 data bits
        spi_xfer(2'b00, {8'h81, 5'b10110, 51'h0}, 13, 1'b1, rx);
        chk("t4_frame_err", 32'(frame_err), 32'h1);

        // T5: reserved op, then a normal mode 2 write
        spi_xfer(2'b00, {8'h40, 16'hFFFF, 40'h0}, 24, 1'b1, rx);
        chk("t5_status", 32'(rx[63:56]), 32'hA5);
        chk("t5_miso_zero", 32'(rx[55:40]), 32'h0);
        chk("t5_frame_err_cleared", 32'(frame_err), 32'h0);
        wr_addr_q.push_back(32'h0A); wr_data_q.push_back(32'h5A5A);
        spi_xfer(2'b10, {8'h8A, 16'h5A5A, 40'h0}, 24, 1'b1, rx);
        chk("t5_m2_status", 32'(rx[63:56]), 32'hA5);

        // T6: reset in the middle of a write burst, then a clean write
        wr_addr_q.push_back(32'h10); wr_data_q.push_back(32'h1111);
        spi_xfer(2'b00, {8'h90, 16'h1111, 4'b1010, 36'h0}, 28, 1'b0, rx);
        @(negedge clk);
        nrst = 1'b0;
        @(posedge clk);
        #1;
        chk_all_zero("t6_reset");
        @(negedge clk);
        nrst = 1'b1;
        nss  = 1'b1;
        #(2*H);
        wr_addr_q.push_back(32'h02); wr_data_q.push_back(32'h1234);
        spi_xfer(2'b00, {8'h82, 16'h1234, 40'h0}, 24, 1'b1, rx);
        chk("t6_frame_err", 32'(frame_err), 32'h0);
        chk("t6_addr_after", 32'(reg_addr), 32'h03);

        repeat (20) @(negedge clk);
        chk("wr_q_drained", 32'(wr_addr_q.size()), 32'h0);
        chk("rd_q_drained", 32'(rd_addr_q.size()), 32'h0);
        chk("fc_q_drained", 32'(fc_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
